// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: 640x480@60 mode defaults,
// the pixel-width helper and the bundle carried through the sync delay line.
package vga_timing_pkg;

    localparam int DEF_H_WIDTH  = 640;
    localparam int DEF_H_PORCH  = 656;
    localparam int DEF_H_SYNCH  = 752;
    localparam int DEF_H_RAW    = 800;
    localparam int DEF_V_HEIGHT = 480;
    localparam int DEF_V_PORCH  = 490;
    localparam int DEF_V_SYNCH  = 492;
    localparam int DEF_V_RAW    = 525;

    function automatic int bpp(input int bits_per_color);
        return 3 * bits_per_color;
    endfunction

    typedef struct packed {
        logic rd;
        logic hs;
        logic vs;
    } sync_bus_t;

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage shift register that holds {rd,hs,vs} back until the requested
// pixel returns; every stage clears on reset.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int N = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  sync_bus_t din,
    output sync_bus_t dout
);

    sync_bus_t stages [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) stages[i] <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < N; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator with pixel-return alignment of de/hsync/vsync.
// Define VGA_TIMING_SHADOW_EN to latch the mode inputs once per frame.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int BITS_PER_COLOR  = 4,
    parameter int HW              = 12,
    parameter int VW              = 12,
    parameter int PIPE_DLY        = 2,
    parameter int SYNC_ACTIVE_LOW = 1,
    localparam int BPP            = bpp(BITS_PER_COLOR)
) (
    input  logic           i_pixclk,
    input  logic           i_reset,
    input  logic [HW-1:0]  i_hm_width,
    input  logic [HW-1:0]  i_hm_porch,
    input  logic [HW-1:0]  i_hm_synch,
    input  logic [HW-1:0]  i_hm_raw,
    input  logic [VW-1:0]  i_vm_height,
    input  logic [VW-1:0]  i_vm_porch,
    input  logic [VW-1:0]  i_vm_synch,
    input  logic [VW-1:0]  i_vm_raw,
    output logic [HW-1:0]  o_width,
    output logic [VW-1:0]  o_height,
    output logic           o_rd,
    output logic           o_newline,
    output logic           o_newframe,
    input  logic [BPP-1:0] i_pixel,
    output logic [BPP-1:0] o_pixel,
    output logic           o_de,
    output logic           o_hsync,
    output logic           o_vsync
);

    logic [HW-1:0] h_width, h_porch, h_synch, h_raw, h_last, hpos;
    logic [VW-1:0] v_height, v_porch, v_synch, v_raw, v_last, vpos;
    logic          line_end, frame_end, hs, vs;
    sync_bus_t     dly;

    // A zero total is treated as one clock/line so the counters still wrap.
    assign h_last    = (h_raw == '0) ? '0 : h_raw - HW'(1);
    assign v_last    = (v_raw == '0) ? '0 : v_raw - VW'(1);
    assign line_end  = (hpos >= h_last);
    assign frame_end = line_end && (vpos >= v_last);

`ifdef VGA_TIMING_SHADOW_EN
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            h_width  <= HW'(DEF_H_WIDTH);
            h_porch  <= HW'(DEF_H_PORCH);
            h_synch  <= HW'(DEF_H_SYNCH);
            h_raw    <= HW'(DEF_H_RAW);
            v_height <= VW'(DEF_V_HEIGHT);
            v_porch  <= VW'(DEF_V_PORCH);
            v_synch  <= VW'(DEF_V_SYNCH);
            v_raw    <= VW'(DEF_V_RAW);
        end else if (frame_end) begin
            h_width  <= i_hm_width;
            h_porch  <= i_hm_porch;
            h_synch  <= i_hm_synch;
            h_raw    <= i_hm_raw;
            v_height <= i_vm_height;
            v_porch  <= i_vm_porch;
            v_synch  <= i_vm_synch;
            v_raw    <= i_vm_raw;
        end
    end
`else
    always_comb begin
        h_width  = i_hm_width;
        h_porch  = i_hm_porch;
        h_synch  = i_hm_synch;
        h_raw    = i_hm_raw;
        v_height = i_vm_height;
        v_porch  = i_vm_porch;
        v_synch  = i_vm_synch;
        v_raw    = i_vm_raw;
    end
`endif

    assign o_width  = h_width;
    assign o_height = v_height;

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            hpos <= '0;
            vpos <= '0;
        end else if (line_end) begin
            hpos <= '0;
            vpos <= (vpos >= v_last) ? '0 : vpos + VW'(1);
        end else begin
            hpos <= hpos + HW'(1);
        end
    end

    // o_rd is a request without back-pressure: the pixel source must return
    // each requested pixel on i_pixel exactly PIPE_DLY cycles after its o_rd.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            o_rd       <= 1'b0;
            o_newline  <= 1'b0;
            o_newframe <= 1'b0;
            hs         <= 1'b0;
            vs         <= 1'b0;
        end else begin
            o_rd       <= (hpos < h_width) && (vpos < v_height);
            o_newline  <= (h_width != '0) && (hpos == h_width) && (vpos < v_height);
            o_newframe <= (h_width != '0) && (v_height != '0) && (hpos == h_width)
                          && (vpos == v_height - VW'(1));
            hs         <= (hpos >= h_porch) && (hpos < h_synch);
            vs         <= (vpos >= v_porch) && (vpos < v_synch);
        end
    end

    vga_sync_delay #(.N(PIPE_DLY)) u_sync_delay (
        .clk  (i_pixclk),
        .rst  (i_reset),
        .din  ('{rd: o_rd, hs: hs, vs: vs}),
        .dout (dly)
    );

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            o_de    <= 1'b0;
            o_pixel <= '0;
            o_hsync <= (SYNC_ACTIVE_LOW != 0);
            o_vsync <= (SYNC_ACTIVE_LOW != 0);
        end else begin
            o_de    <= dly.rd;
            o_pixel <= dly.rd ? i_pixel : '0;
            o_hsync <= (SYNC_ACTIVE_LOW != 0) ? ~dly.hs : dly.hs;
            o_vsync <= (SYNC_ACTIVE_LOW != 0) ? ~dly.vs : dly.vs;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small 8/10/12/14 x 4/5/6/7 mode, with a
// position-level model checked every cycle plus directed literal checks.
module tb_vga_timing_gen;

    localparam int HW  = 12;
    localparam int VW  = 12;
    localparam int BPP = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [HW-1:0]  hm_width = 12'd8, hm_porch = 12'd10, hm_synch = 12'd12, hm_raw = 12'd14;
    logic [VW-1:0]  vm_height = 12'd4, vm_porch = 12'd5, vm_synch = 12'd6, vm_raw = 12'd7;
    logic [BPP-1:0] pix_in = '0;
    logic [HW-1:0]  width;
    logic [VW-1:0]  height;
    logic           rd, newline, newframe, de, hsync, vsync;
    logic [BPP-1:0] pix_out;

    int compared   = 0;
    int mismatched = 0;

    vga_timing_gen #(
        .BITS_PER_COLOR(4), .HW(HW), .VW(VW), .PIPE_DLY(2), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .i_pixclk(clk), .i_reset(rst),
        .i_hm_width(hm_width), .i_hm_porch(hm_porch), .i_hm_synch(hm_synch), .i_hm_raw(hm_raw),
        .i_vm_height(vm_height), .i_vm_porch(vm_porch), .i_vm_synch(vm_synch), .i_vm_raw(vm_raw),
        .o_width(width), .o_height(height),
        .o_rd(rd), .o_newline(newline), .o_newframe(newframe),
        .i_pixel(pix_in), .o_pixel(pix_out), .o_de(de), .o_hsync(hsync), .o_vsync(vsync)
    );

    always #5 clk = ~clk;

    initial begin
        #30_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- model: raster position from the mode rules -----------
    int p_h = 0, p_v = 0, k = 0, cyc = 0;
    int s_w, s_hp, s_hs, s_hr, s_vh, s_vp, s_vs, s_vr;
    logic           hist_rd [16];
    logic           hist_hs [16];
    logic           hist_vs [16];
    logic [BPP-1:0] hist_val[16];
    logic [BPP-1:0] drv     [16];

    task automatic shadow_defaults();
        s_w = 640; s_hp = 656; s_hs = 752; s_hr = 800;
        s_vh = 480; s_vp = 490; s_vs = 492; s_vr = 525;
    endtask

    initial begin
        logic [41:0] act, exp;
        logic e_rd, e_nl, e_nf, e_de, e_ho, e_vo, fe;
        logic [BPP-1:0] e_pix;
        int w, hp, hsn, hr, vh, vp, vsn, vr, idx, ew, eh;
        shadow_defaults();
        for (int i = 0; i < 16; i++) begin
            hist_rd[i] = 0; hist_hs[i] = 0; hist_vs[i] = 0; hist_val[i] = '0; drv[i] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            idx = cyc % 16;
            if (rst) begin
                p_h = 0; p_v = 0; k = 0;
                shadow_defaults();
                for (int i = 0; i < 16; i++) begin
                    hist_rd[i] = 0; hist_hs[i] = 0; hist_vs[i] = 0;
                end
                e_rd = 0; e_nl = 0; e_nf = 0; e_de = 0; e_ho = 1; e_vo = 1; e_pix = '0;
            end else begin
`ifdef VGA_TIMING_SHADOW_EN
                w = s_w; hp = s_hp; hsn = s_hs; hr = s_hr; vh = s_vh; vp = s_vp; vsn = s_vs; vr = s_vr;
`else
                w = hm_width; hp = hm_porch; hsn = hm_synch; hr = hm_raw;
                vh = vm_height; vp = vm_porch; vsn = vm_synch; vr = vm_raw;
`endif
                if (hr == 0) hr = 1;
                if (vr == 0) vr = 1;
                e_rd = (p_h < w) && (p_v < vh);
                e_nl = (w != 0) && (p_h == w) && (p_v < vh);
                e_nf = (w != 0) && (vh != 0) && (p_h == w) && (p_v == vh - 1);
                hist_rd[idx] = e_rd;
                hist_hs[idx] = (p_h >= hp) && (p_h < hsn);
                hist_vs[idx] = (p_v >= vp) && (p_v < vsn);
                if (e_rd) begin
                    hist_val[idx] = BPP'(12'h100 + k);
                    k++;
                end
                fe = (p_h >= hr - 1) && (p_v >= vr - 1);
                if (p_h >= hr - 1) begin
                    p_h = 0;
                    p_v = (p_v >= vr - 1) ? 0 : p_v + 1;
                end else begin
                    p_h++;
                end
`ifdef VGA_TIMING_SHADOW_EN
                if (fe) begin
                    s_w = hm_width; s_hp = hm_porch; s_hs = hm_synch; s_hr = hm_raw;
                    s_vh = vm_height; s_vp = vm_porch; s_vs = vm_synch; s_vr = vm_raw;
                end
`endif
                // outputs show the decode of three cycles ago, pixel from last cycle
                e_de  = hist_rd[(cyc + 13) % 16];
                e_ho  = ~hist_hs[(cyc + 13) % 16];
                e_vo  = ~hist_vs[(cyc + 13) % 16];
                e_pix = e_de ? drv[(cyc + 15) % 16] : '0;
            end
`ifdef VGA_TIMING_SHADOW_EN
            ew = s_w; eh = s_vh;
`else
            ew = hm_width; eh = vm_height;
`endif
            act = {rd, newline, newframe, de, hsync, vsync, pix_out, width, height};
            exp = {e_rd, e_nl, e_nf, e_de, e_ho, e_vo, e_pix, HW'(ew), VW'(eh)};
            compared++;
            if (act !== exp) begin
                mismatched++;
                $display("FAIL cycle_model @%0d: {rd,nl,nf,de,hs,vs,pix,w,h} got %b_%h_%h_%h expected %b_%h_%h_%h",
                         cyc, act[41:36], act[35:24], act[23:12], act[11:0],
                         exp[41:36], exp[35:24], exp[23:12], exp[11:0]);
            end
            if (!rst && hist_rd[(cyc + 14) % 16]) pix_in = hist_val[(cyc + 14) % 16];
            else pix_in = BPP'($urandom);
            drv[idx] = pix_in;
        end
    end

    // ---------------- directed sequence ------------------------------------
`ifdef VGA_TIMING_SHADOW_EN
    localparam int FIRST_W  = 640;
    localparam int FIRST_HS = 1;
`else
    localparam int FIRST_W  = 8;
    localparam int FIRST_HS = 0;
`endif

    task automatic check_release(input string tag);
        logic r_rd[17], r_de[17], r_hs[17];
        logic [BPP-1:0] r_pix[17];
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            r_rd[i] = rd; r_de[i] = de; r_hs[i] = hsync; r_pix[i] = pix_out;
        end
        for (int i = 1; i <= 14; i++)
            check($sformatf("%s_rd_cycle%0d", tag, i), int'(r_rd[i]), int'(i <= FIRST_W));
        check({tag, "_de_c3"}, int'(r_de[3]), 0);
        check({tag, "_de_c4"}, int'(r_de[4]), 1);
        check({tag, "_pix_c4"}, int'(r_pix[4]), 'h100);
        check({tag, "_pix_c11"}, int'(r_pix[11]), 'h107);
        check({tag, "_hs_c13"}, int'(r_hs[13]), 1);
        check({tag, "_hs_c14"}, int'(r_hs[14]), FIRST_HS);
        check({tag, "_hs_c16"}, int'(r_hs[16]), 1);
        if (FIRST_W == 8) check({tag, "_pix_c12"}, int'(r_pix[12]), 0);
    endtask

    task automatic wait_small_mode();
`ifdef VGA_TIMING_SHADOW_EN
        int n = 0;
        while (width !== hm_width && n < 450000) begin
            @(negedge clk);
            n++;
        end
        check("wait_small_mode_timeout", int'(width === hm_width), 1);
`endif
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p_h == h && p_v == v) && n < 2000);
        check($sformatf("wait_pos_%0d_%0d_timeout", h, v), int'(p_h == h && p_v == v), 1);
    endtask

    initial begin
        int c_rd, c_nl, c_nf, c_nf_only, c_hlo, c_vlo, c_de, c_pix_blank;

        // 1: reset values, then the first line after release
        repeat (3) @(negedge clk);
        check("rst_rd", int'(rd), 0);
        check("rst_newline", int'(newline), 0);
        check("rst_newframe", int'(newframe), 0);
        check("rst_de", int'(de), 0);
        check("rst_pixel", int'(pix_out), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_width", int'(width), FIRST_W);
        rst = 1'b0;
        check_release("rel1");

        // 2/3/4: three frames of steady-state counts
        wait_small_mode();
        c_rd = 0; c_nl = 0; c_nf = 0; c_nf_only = 0; c_hlo = 0; c_vlo = 0; c_de = 0; c_pix_blank = 0;
        repeat (294) begin
            @(negedge clk);
            c_rd += int'(rd);
            c_nl += int'(newline);
            c_nf += int'(newframe);
            c_nf_only += int'(newframe && !newline);
            c_hlo += int'(!hsync);
            c_vlo += int'(!vsync);
            c_de += int'(de);
            c_pix_blank += int'(!de && pix_out != '0);
        end
        check("frames_rd_count", c_rd, 96);
        check("frames_newline_count", c_nl, 12);
        check("frames_newframe_count", c_nf, 3);
        check("frames_newframe_without_newline", c_nf_only, 0);
        check("frames_hsync_low_clocks", c_hlo, 42);
        check("frames_vsync_low_clocks", c_vlo, 42);
        check("frames_de_count", c_de, 96);
        check("frames_pixel_nonzero_in_blanking", c_pix_blank, 0);

        // 5: reset in the middle of line 2
        wait_pos(5, 2);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_rd", int'(rd), 0);
            check("midrst_newline", int'(newline), 0);
            check("midrst_newframe", int'(newframe), 0);
        end
        rst = 1'b0;
        check_release("rel2");

        // 6: shrink the active width mid-frame
        wait_small_mode();
        wait_pos(3, 1);
        hm_width = 12'd6;
        wait_pos(0, 2);
        c_rd = 0;
        repeat (14) begin
            @(negedge clk);
            c_rd += int'(rd);
        end
`ifdef VGA_TIMING_SHADOW_EN
        check("shrink_next_line_rd", c_rd, 8);
        check("shrink_o_width", int'(width), 8);
`else
        check("shrink_next_line_rd", c_rd, 6);
        check("shrink_o_width", int'(width), 6);
`endif
        repeat (200) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
